z80_bus_responder: RTL

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

---
 rtl/z80_bus_pkg.sv | 24 ++
 rtl/z80_cycle_decode.sv | 33 +++
 rtl/z80_bus_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: FSM states, bus-cycle classes,
// reset read data and wait-counter helpers.
package z80_bus_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef enum logic [2:0] {NONE, MEM_RD, MEM_WR, IO_RD, IO_WR, INTACK} cls_t;

    localparam logic [7:0] DI_RESET = 8'hFF;

    // The counter is only 4 bits, so a target above 15 could never be met.
    function automatic logic [3:0] wait_target(input int wmin, input int extra);
        int t;
        t = wmin + extra;
        if (t > 15) t = 15;
        if (t < 0) t = 0;
        return 4'(t);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// Combinational classifier of the Z80 strobes into a bus-cycle class.
// Interrupt acknowledge is only recognised when Z80_BUS_INTACK_EN is defined.
module z80_cycle_decode
    import z80_bus_pkg::*;
(
    input  logic mreq_n,
    input  logic iorq_n,
    input  logic rd_n,
    input  logic wr_n,
    input  logic m1_n,
    input  logic rfsh_n,
    output cls_t cls
);

    always_comb begin
        cls = NONE;
        if (!rfsh_n)
            cls = NONE;
        else if (!mreq_n && !rd_n)
            cls = MEM_RD;
        else if (!mreq_n && !wr_n)
            cls = MEM_WR;
        else if (!iorq_n && !rd_n && m1_n)
            cls = IO_RD;
        else if (!iorq_n && !wr_n)
            cls = IO_WR;
`ifdef Z80_BUS_INTACK_EN
        else if (!m1_n && !iorq_n)
            cls = INTACK;
`endif
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Turns Z80 bus cycles into single backend requests, stretching wait_n until the
// backend acks and a minimum wait count elapses. INTACK support: Z80_BUS_INTACK_EN.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int WAIT_MIN = 0,
    parameter int IO_EXTRA = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cen,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    output logic        bk_req,
    output logic        bk_we,
    output logic        bk_io,
    output logic [15:0] bk_addr,
    output logic [7:0]  bk_wdata,
    input  logic        bk_ack,
    input  logic [7:0]  bk_rdata,
    input  logic [7:0]  int_vec
);

    localparam logic [3:0] TGT_MEM = wait_target(WAIT_MIN, 0);
    localparam logic [3:0] TGT_IO  = wait_target(WAIT_MIN, IO_EXTRA);

    state_t     state;
    cls_t       cur_cls;
    cls_t       lat_cls;
    logic       ack_seen;
    logic       aborted;
    logic [3:0] cnt;

    logic       is_io;
    logic       is_rd;
    logic       abort_now;
    logic       ack_now;
    logic [3:0] tgt;

    z80_cycle_decode u_decode (
        .mreq_n (mreq_n),
        .iorq_n (iorq_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .m1_n   (m1_n),
        .rfsh_n (rfsh_n),
        .cls    (cur_cls)
    );

    // Strobes vanishing mid-access mark it aborted: it still completes, but read data is dropped.
    always_comb begin
        is_io     = (lat_cls == IO_RD) || (lat_cls == IO_WR) || (lat_cls == INTACK);
        is_rd     = (lat_cls == MEM_RD) || (lat_cls == IO_RD);
        tgt       = is_io ? TGT_IO : TGT_MEM;
        abort_now = aborted || (cur_cls == NONE);
        ack_now   = ack_seen || bk_ack;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_cls  <= NONE;
            wait_n   <= 1'b1;
            cpu_di   <= DI_RESET;
            bk_req   <= 1'b0;
            bk_we    <= 1'b0;
            bk_io    <= 1'b0;
            bk_addr  <= '0;
            bk_wdata <= '0;
            ack_seen <= 1'b0;
            aborted  <= 1'b0;
            cnt      <= '0;
        end else if (cen) begin
            case (state)
                IDLE: begin
                    if (cur_cls != NONE) begin
                        state    <= ISSUE;
                        lat_cls  <= cur_cls;
                        bk_addr  <= A;
                        bk_wdata <= cpu_dout;
                        bk_we    <= (cur_cls == MEM_WR) || (cur_cls == IO_WR);
                        bk_io    <= (cur_cls == IO_RD) || (cur_cls == IO_WR);
                        bk_req   <= (cur_cls != INTACK);
                        wait_n   <= 1'b0;
                        ack_seen <= 1'b0;
                        aborted  <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ISSUE: begin
                    bk_req  <= 1'b0;
                    state   <= WAIT;
                    cnt     <= sat_inc(cnt);
                    aborted <= abort_now;
                    if (lat_cls == INTACK) begin
                        ack_seen <= 1'b1;
                        if (!abort_now) cpu_di <= int_vec;
                    end else if (bk_ack) begin
                        ack_seen <= 1'b1;
                        if (is_rd && !abort_now) cpu_di <= bk_rdata;
                    end
                end
                WAIT: begin
                    cnt     <= sat_inc(cnt);
                    aborted <= abort_now;
                    if (bk_ack && !ack_seen) begin
                        ack_seen <= 1'b1;
                        if (is_rd && !abort_now) cpu_di <= bk_rdata;
                    end
                    if (ack_now && (cnt >= tgt)) begin
                        state  <= HOLD;
                        wait_n <= 1'b1;
                    end
                end
                HOLD: begin
                    // Waiting for the strobes to drop keeps one assertion to one request.
                    if (cur_cls == NONE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
